sipo: RTL and testbench

- Serial-in, parallel-out shift register.
- Captures one serial bit per rising clock edge into a WIDTH-bit parallel word.
- Flags each completed WIDTH-bit frame with a one-cycle valid pulse.
- Used as a deserialiser front end: a serial line or bit-stream source feeds a parallel consumer that samples po when po_valid is high.

---
 rtl/sipo.sv | 52 +++++
 tb/tb_sipo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sipo.sv
// Serial-in, parallel-out shift register with a one-cycle frame-complete pulse.
// Optional feature: define SIPO_PARITY_EN to add the registered po_parity output.
module sipo #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  output logic [CW-1:0]    bit_cnt
`ifdef SIPO_PARITY_EN
  ,
  output logic             po_parity
`endif
);

  logic [WIDTH-1:0] po_nxt;
  logic             frame_done;

  always_comb begin
    po_nxt = po;
    if (MSB_FIRST) po_nxt = {po[WIDTH-2:0], si};
    else           po_nxt = {si, po[WIDTH-1:1]};
  end

  // Explicit compare keeps non-power-of-2 WIDTH correct; depends only on
  // bit_cnt so an X on si cannot leak into the count or the valid pulse.
  assign frame_done = (bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      po       <= '0;
      bit_cnt  <= '0;
      po_valid <= 1'b0;
    end else begin
      po       <= po_nxt;
      bit_cnt  <= frame_done ? '0 : bit_cnt + CW'(1);
      po_valid <= frame_done;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            po_parity <= 1'b0;
    else if (frame_done) po_parity <= ^po_nxt;
  end
`endif

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: three instances (MSB-first, LSB-first, WIDTH=5)
// compared every cycle against a bit-history model, plus literal frame checks.
module tb_sipo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       si  = 1'b0;

  logic [3:0] po_m, po_l;
  logic [4:0] po_5;
  logic       v_m, v_l, v_5;
  logic [1:0] c_m, c_l;
  logic [2:0] c_5;
`ifdef SIPO_PARITY_EN
  logic       p_m, p_l, p_5;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sipo #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .si(si), .po(po_m), .po_valid(v_m), .bit_cnt(c_m)
`ifdef SIPO_PARITY_EN
    , .po_parity(p_m)
`endif
  );

  sipo #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .si(si), .po(po_l), .po_valid(v_l), .bit_cnt(c_l)
`ifdef SIPO_PARITY_EN
    , .po_parity(p_l)
`endif
  );

  sipo #(.WIDTH(5), .MSB_FIRST(1'b1)) u_w5 (
    .clk(clk), .rst(rst), .si(si), .po(po_5), .po_valid(v_5), .bit_cnt(c_5)
`ifdef SIPO_PARITY_EN
    , .po_parity(p_5)
`endif
  );

  // Model: history of bits captured since the last reset (newest in bit 0),
  // the number of bits captured, and the parity of the last completed frame.
  logic [31:0] hist;
  int unsigned n;
  logic        par4, par5;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      n    <= 0;
      par4 <= 1'b0;
      par5 <= 1'b0;
    end else begin
      hist <= {hist[30:0], si};
      n    <= n + 1;
      if ((n + 1) % 4 == 0) par4 <= ^{hist[2:0], si};
      if ((n + 1) % 5 == 0) par5 <= ^{hist[3:0], si};
    end
  end

  function automatic logic [31:0] exp_po(input int w, input bit msb);
    logic [31:0] e = '0;
    for (int i = 0; i < w; i++) begin
      if (msb) e[i] = hist[i];
      else     e[w-1-i] = hist[i];
    end
    return e;
  endfunction

  function automatic logic [31:0] exp_valid(input int w);
    return {31'b0, (n != 0) && (n % w == 0)};
  endfunction

  function automatic logic [31:0] exp_cnt(input int w);
    return n % w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    chk("m.po",  {28'b0, po_m}, exp_po(4, 1'b1));
    chk("m.val", {31'b0, v_m},  exp_valid(4));
    chk("m.cnt", {30'b0, c_m},  exp_cnt(4));
    chk("l.po",  {28'b0, po_l}, exp_po(4, 1'b0));
    chk("l.val", {31'b0, v_l},  exp_valid(4));
    chk("l.cnt", {30'b0, c_l},  exp_cnt(4));
    chk("5.po",  {27'b0, po_5}, exp_po(5, 1'b1));
    chk("5.val", {31'b0, v_5},  exp_valid(5));
    chk("5.cnt", {29'b0, c_5},  exp_cnt(5));
`ifdef SIPO_PARITY_EN
    chk("m.par", {31'b0, p_m}, {31'b0, par4});
    chk("l.par", {31'b0, p_l}, {31'b0, par4});
    chk("5.par", {31'b0, p_5}, {31'b0, par5});
`endif
  end

  // Called at negedge+1: present a bit, let one rising edge pass, return at negedge+1.
  task automatic step(input logic b);
    si = b;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_m(input string name, input logic [3:0] p, input logic v, input logic [1:0] c);
    chk({name, ".po"},  {28'b0, po_m}, {28'b0, p});
    chk({name, ".val"}, {31'b0, v_m},  {31'b0, v});
    chk({name, ".cnt"}, {30'b0, c_m},  {30'b0, c});
  endtask

  logic [3:0] f1_bits = 4'b1011;
  logic [3:0] f1_po [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
  logic [7:0] b2b_bits = 8'b11000111;
  logic [3:0] mr_bits = 4'b0101;

  initial begin
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    // Reset held with si toggling.
    for (int i = 0; i < 3; i++) begin
      step(i[0]);
      chk_m("rst_hold", 4'b0000, 1'b0, 2'd0);
    end

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(f1_bits[3-i]);
      chk_m("frame1", f1_po[i], (i == 3), 2'(i + 1));
    end
    chk("frame1.lsb_po", {28'b0, po_l}, 32'hD);
    chk("frame1.lsb_val", {31'b0, v_l}, 32'h1);
    chk("frame1.w5_po", {27'b0, po_5}, 32'h0B);
    chk("frame1.w5_cnt", {29'b0, c_5}, 32'h4);
`ifdef SIPO_PARITY_EN
    chk("frame1.par", {31'b0, p_m}, 32'h1);
`endif

    for (int i = 0; i < 8; i++) begin
      step(b2b_bits[7-i]);
`ifdef SIPO_PARITY_EN
      if (i == 0) chk("b2b.par_hold", {31'b0, p_m}, 32'h1);
      if (i == 3) chk("b2b.par1", {31'b0, p_m}, 32'h0);
      if (i == 7) chk("b2b.par2", {31'b0, p_m}, 32'h1);
`endif
      if (i == 2) chk("b2b.gap", {31'b0, v_m}, 32'h0);
      if (i == 3) chk_m("b2b.f1", 4'b1100, 1'b1, 2'd0);
      if (i == 7) chk_m("b2b.f2", 4'b0111, 1'b1, 2'd0);
    end

    // Mid-frame reset, asserted between edges.
    step(1'b1);
    step(1'b1);
    chk("mid.noval", {31'b0, v_m}, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk_m("async_clr", 4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(mr_bits[3-i]);
      if (i < 3) chk("mid.noval2", {31'b0, v_m}, 32'h0);
    end
    chk_m("mid.frame", 4'b0101, 1'b1, 2'd0);
`ifdef SIPO_PARITY_EN
    chk("mid.par", {31'b0, p_m}, 32'h0);
`endif

    // Random stream with occasional short asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      si = 1'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        #1 si = 1'($urandom);
      end
      @(negedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
